serial_msg_receiver: RTL and testbench

//  Downstream stage of the 1-wire-plus-strobe serial link driven by the serial transmitter.

---
 rtl/alarm_serial_pkg.sv | 11 +
 rtl/serial_msg_receiver_link_watchdog.sv | 45 ++++
 rtl/serial_msg_receiver.sv | 150 +++++++++++++++
 tb/tb_serial_msg_receiver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alarm_serial_pkg.sv
// Shared definitions for the alarm-state serial link (transmitter and receiver).
package alarm_serial_pkg;

  localparam int DEFAULT_MSG_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_msg_receiver_link_watchdog.sv
// Saturating link watchdog: counts enabled cycles since the last completed frame.
module link_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             expired_r;

  // Next count: clear wins, otherwise count enabled cycles up to the limit
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (EN && (cnt_r != LIMIT)) begin
      cnt_nxt_s = cnt_r + ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and expiry flag registers; expiry is registered from the next count
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r     <= {CNT_W{1'b0}};
      expired_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      expired_r <= (cnt_nxt_s == LIMIT);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/serial_msg_receiver.sv
// Deserializes strobe-framed alarm words, optionally confirming each word by two
// identical consecutive frames, and reports framing errors and link loss.
module serial_msg_receiver
  import alarm_serial_pkg::*;
#(
  parameter int MSG_W   = DEFAULT_MSG_W,
  parameter int CONFIRM = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             state_send,
  input  logic             state_out,
  output logic [MSG_W-1:0] msg,
  output logic             msg_valid,
  output logic             msg_changed,
  output logic             frame_err,
  output logic             link_lost
);

  localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             CONFIRM_EN = (CONFIRM != 0);

  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_nxt_s;
  logic [MSG_W-1:0] shift_r;
  logic [MSG_W-1:0] shift_nxt_s;
  logic [MSG_W-1:0] cand_r;
  logic             cand_valid_r;
  logic [MSG_W-1:0] msg_r;
  logic             msg_valid_r;
  logic             msg_changed_r;
  logic             frame_err_r;
  logic             frame_done_s;
  logic             frame_abort_s;
  logic             accept_s;

  // FSM state and bit counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      bit_cnt_r <= CNT_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  // Next state: a start strobe seen mid-frame restarts the frame from bit 0
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (EN && state_send) begin
          state_nxt_s   = SHIFT;
          bit_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s   = IDLE;
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
      SHIFT: begin
        if (!EN) begin
          state_nxt_s   = IDLE;
          bit_cnt_nxt_s = CNT_ZERO;
        end else if (state_send) begin
          state_nxt_s   = SHIFT;
          bit_cnt_nxt_s = CNT_ZERO;
        end else if (bit_cnt_r == LAST_BIT) begin
          state_nxt_s   = IDLE;
          bit_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s   = SHIFT;
          bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bit_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Frame decode: shift data, detect completion/abort, decide acceptance
  always_comb begin
    shift_nxt_s   = shift_r;
    frame_done_s  = 1'b0;
    frame_abort_s = 1'b0;
    if ((state_r == SHIFT) && EN) begin
      if (state_send) begin
        frame_abort_s = 1'b1;
      end else begin
        shift_nxt_s[bit_cnt_r] = state_out;
        frame_done_s           = (bit_cnt_r == LAST_BIT);
      end
    end else begin
      frame_done_s  = 1'b0;
      frame_abort_s = 1'b0;
    end
    accept_s = frame_done_s && (!CONFIRM_EN || (cand_valid_r && (cand_r == shift_nxt_s)));
  end

  // Datapath and output registers; every completed frame becomes the new candidate
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_r       <= {MSG_W{1'b0}};
      cand_r        <= {MSG_W{1'b0}};
      cand_valid_r  <= 1'b0;
      msg_r         <= {MSG_W{1'b0}};
      msg_valid_r   <= 1'b0;
      msg_changed_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      shift_r <= shift_nxt_s;
      if (frame_done_s) begin
        cand_r       <= shift_nxt_s;
        cand_valid_r <= 1'b1;
      end
      if (accept_s) begin
        msg_r <= shift_nxt_s;
      end
      msg_valid_r   <= accept_s;
      msg_changed_r <= accept_s && (shift_nxt_s != msg_r);
      frame_err_r   <= frame_abort_s;
    end
  end

  link_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .clear  (frame_done_s),
    .expired(link_lost)
  );

  assign msg         = msg_r;
  assign msg_valid   = msg_valid_r;
  assign msg_changed = msg_changed_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_serial_msg_receiver.sv
// Directed bench: per-cycle vector table on a CONFIRM=0 receiver, hand sequences
// for confirmation (CONFIRM=1) and watchdog timeout.
module tb_serial_msg_receiver;

  localparam int MSG_W = 4;
  localparam int TMO   = 16;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ss;
    logic       so;
    logic [3:0] msg;
    logic       v;
    logic       c;
    logic       e;
    logic       l;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic ss  = 1'b0;
  logic so  = 1'b0;

  logic [MSG_W-1:0] m0, m1;
  logic v0, c0, e0, l0;
  logic v1, c1, e1, l1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  serial_msg_receiver #(.MSG_W(MSG_W), .CONFIRM(0), .TIMEOUT(TMO)) dut0 (
    .CLK(clk), .RST(rst), .EN(en), .state_send(ss), .state_out(so),
    .msg(m0), .msg_valid(v0), .msg_changed(c0), .frame_err(e0), .link_lost(l0)
  );

  serial_msg_receiver #(.MSG_W(MSG_W), .CONFIRM(1), .TIMEOUT(TMO)) dut1 (
    .CLK(clk), .RST(rst), .EN(en), .state_send(ss), .state_out(so),
    .msg(m1), .msg_valid(v1), .msg_changed(c1), .frame_err(e1), .link_lost(l1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic o);
    rst = r; en = e; ss = s; so = o;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e, input logic s, input logic o,
                     input logic [3:0] m, input logic v, input logic c,
                     input logic fe, input logic l);
    vec_t t;
    t.rst = r; t.en = e; t.ss = s; t.so = o;
    t.msg = m; t.v = v; t.c = c; t.e = fe; t.l = l;
    vecs.push_back(t);
  endtask

  // CONFIRM=1 frame: start strobe then MSG_W bits LSB first, pulses checked at completion
  task automatic frame1(input string tag, input logic [3:0] w, input logic exp_v,
                        input logic exp_c, input logic [3:0] exp_msg);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk({tag, " start valid"}, {31'd0, v1}, 32'd0);
    for (int b = 0; b < MSG_W; b++) begin
      step(1'b0, 1'b1, 1'b0, w[b]);
      if (b < MSG_W - 1) begin
        chk($sformatf("%s bit%0d valid", tag, b), {31'd0, v1}, 32'd0);
      end else begin
        chk({tag, " valid"},   {31'd0, v1}, {31'd0, exp_v});
        chk({tag, " changed"}, {31'd0, c1}, {31'd0, exp_c});
        chk({tag, " msg"},     {28'd0, m1}, {28'd0, exp_msg});
        chk({tag, " ferr"},    {31'd0, e1}, 32'd0);
      end
    end
  endtask

  initial begin
    // Reset, then reset mid-frame after two bits, then fresh 0x9
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
    // 0x5 = bits 1,0,1,0
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    // Restart after two bits, then 0xA = bits 0,1,0,1
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    // Partial frame (watchdog reaches 3), EN low 5 cycles with a stray start
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add(1'b0, 1'b0, (k == 2), 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Idle with EN: watchdog 4..15 then 16 (link_lost), saturated
    for (int k = 0; k < 14; k++) begin
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, (k >= 12));
    end
    // 0x6 = bits 0,1,1,0 clears link_lost at completion
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
    // Same word again: valid without changed
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ss, vecs[i].so);
      chk($sformatf("row%0d msg", i),     {28'd0, m0}, {28'd0, vecs[i].msg});
      chk($sformatf("row%0d valid", i),   {31'd0, v0}, {31'd0, vecs[i].v});
      chk($sformatf("row%0d changed", i), {31'd0, c0}, {31'd0, vecs[i].c});
      chk($sformatf("row%0d ferr", i),    {31'd0, e0}, {31'd0, vecs[i].e});
      chk($sformatf("row%0d lost", i),    {31'd0, l0}, {31'd0, vecs[i].l});
    end

    // Confirmation on the CONFIRM=1 instance
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c1 reset msg",   {28'd0, m1}, 32'd0);
    chk("c1 reset valid", {31'd0, v1}, 32'd0);
    chk("c1 reset lost",  {31'd0, l1}, 32'd0);
    frame1("c1 f3a", 4'h3, 1'b0, 1'b0, 4'h0);
    frame1("c1 f6a", 4'h6, 1'b0, 1'b0, 4'h0);
    frame1("c1 f6b", 4'h6, 1'b1, 1'b1, 4'h6);
    frame1("c1 f6c", 4'h6, 1'b1, 1'b0, 4'h6);
    frame1("c1 f9",  4'h9, 1'b0, 1'b0, 4'h6);

    // Watchdog from reset: still clear after 15 enabled cycles, set at the 16th
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TMO - 1; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("wd lost at 15", {31'd0, l0}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wd lost at 16", {31'd0, l0}, 32'd1);
    chk("wd msg held",   {28'd0, m0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
